// File: rtl/tmds_word_aligner.sv
// Serial TMDS word aligner: shifts in one bit per clock, frames 10-bit symbols and
// slips the boundary one bit at a time until DVI control tokens repeat, then supervises lock.
module tmds_word_aligner #(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_WORDS = 16,
  parameter int LOSS_WORDS   = 2048
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sin,
  output logic [9:0] word,
  output logic       word_valid,
  output logic       locked,
  output logic [3:0] phase
);

  localparam int WIN_W = (SEARCH_WORDS > 1) ? $clog2(SEARCH_WORDS) : 1;
  localparam int RUN_W = $clog2(CTRL_RUN + 1);
  localparam int GAP_W = (LOSS_WORDS > 1) ? $clog2(LOSS_WORDS) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SEARCH_WORDS - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LOSS_WORDS - 1);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t           state;
  logic [9:0]       sr;
  logic [3:0]       cnt;
  logic [WIN_W-1:0] win;
  logic [RUN_W-1:0] run;
  logic [GAP_W-1:0] gap;
  logic             is_ctrl;
  logic             slip;

  function automatic logic ctrl_token(input logic [9:0] w);
    return (w == 10'b1101010100) || (w == 10'b0010101011) ||
           (w == 10'b0101010100) || (w == 10'b1010101011);
  endfunction

  assign is_ctrl = ctrl_token(word);

  // A slip is only ever requested on a strobe cycle, when cnt is already 0.
  always_comb begin
    slip = 1'b0;
    if (word_valid) begin
      case (state)
        SEARCH:  slip = !is_ctrl && (win == WIN_LAST);
        VERIFY:  slip = !is_ctrl;
        LOCKED:  slip = !is_ctrl && (gap == GAP_LAST);
        default: slip = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr         <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      phase      <= '0;
      state      <= SEARCH;
      win        <= '0;
      run        <= '0;
      gap        <= '0;
    end else begin
      sr         <= {sin, sr[9:1]};
      word_valid <= (cnt == 4'd9);
      if (cnt == 4'd9) begin
        word <= {sin, sr[9:1]};
        cnt  <= '0;
      end else if (!slip) begin
        cnt <= cnt + 4'd1;
      end
      if (slip) phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;

      if (word_valid) begin
        case (state)
          SEARCH: begin
            if (is_ctrl) begin
              win <= '0;
              if (CTRL_RUN <= 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
                gap    <= '0;
              end else begin
                state <= VERIFY;
                run   <= RUN_W'(1);
              end
            end else if (slip) begin
              win <= '0;
            end else begin
              win <= win + WIN_W'(1);
            end
          end
          VERIFY: begin
            if (is_ctrl) begin
              if (run == RUN_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
                run    <= '0;
                gap    <= '0;
              end else begin
                run <= run + RUN_W'(1);
              end
            end else begin
              state <= SEARCH;
              run   <= '0;
              win   <= '0;
            end
          end
          LOCKED: begin
            if (is_ctrl) begin
              gap <= '0;
            end else if (slip) begin
              state  <= SEARCH;
              locked <= 1'b0;
              gap    <= '0;
              win    <= '0;
            end else begin
              gap <= gap + GAP_W'(1);
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Randomized scoreboard bench for tmds_word_aligner: a bit-array framing model predicts
// every strobe (time, word, lock, phase); a monitor compares whenever word_valid rises.
module tb_tmds_word_aligner;

  localparam int CTRL_RUN     = 8;
  localparam int SEARCH_WORDS = 16;
  localparam int LOSS_WORDS   = 256;
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;
  localparam logic [9:0] FALSE_DATA = 10'b0111110000;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic [9:0] word;
  logic       word_valid;
  logic       locked;
  logic [3:0] phase;

  tmds_word_aligner #(
    .CTRL_RUN(CTRL_RUN),
    .SEARCH_WORDS(SEARCH_WORDS),
    .LOSS_WORDS(LOSS_WORDS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sin(sin),
    .word(word),
    .word_valid(word_valid),
    .locked(locked),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] word;
    logic       locked;
    logic [3:0] phase;
    int         at;
  } exp_t;

  typedef enum {HUNT, CONFIRM, HELD} mode_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  exp_t  sb[$];
  bit    mbits[$];
  int    m_pos;
  mode_t m_mode;
  int    m_streak, m_miss, m_quiet, m_slips;
  int    bitno = 0;
  bit    armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_token(input logic [9:0] w);
    return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    do w = 10'($urandom); while (is_token(w));
    return w;
  endfunction

  task automatic model_reset();
    mbits.delete();
    m_pos = 0; m_mode = HUNT;
    m_streak = 0; m_miss = 0; m_quiet = 0; m_slips = 0;
  endtask

  // Frames the recorded bit history at the current boundary and applies the lock rules.
  task automatic model_bit(input bit b);
    exp_t e;
    logic [9:0] w;
    bit tok, slip;
    mbits.push_back(b);
    if (mbits.size() == m_pos + 10) begin
      for (int i = 0; i < 10; i++) w[i] = mbits[m_pos + i];
      e.word = w; e.locked = (m_mode == HELD); e.phase = 4'(m_slips % 10); e.at = m_pos + 10;
      sb.push_back(e);
      tok = is_token(w);
      slip = 1'b0;
      case (m_mode)
        HUNT: begin
          if (tok) begin
            m_miss = 0; m_streak = 1; m_quiet = 0;
            if (m_streak >= CTRL_RUN) m_mode = HELD; else m_mode = CONFIRM;
          end else begin
            m_miss++;
            if (m_miss == SEARCH_WORDS) begin slip = 1'b1; m_miss = 0; end
          end
        end
        CONFIRM: begin
          if (tok) begin
            m_streak++;
            if (m_streak == CTRL_RUN) begin m_mode = HELD; m_quiet = 0; end
          end else begin
            slip = 1'b1; m_mode = HUNT; m_miss = 0;
          end
        end
        default: begin
          if (tok) m_quiet = 0;
          else begin
            m_quiet++;
            if (m_quiet == LOSS_WORDS) begin slip = 1'b1; m_mode = HUNT; m_miss = 0; end
          end
        end
      endcase
      if (slip) m_slips++;
      m_pos += slip ? 11 : 10;
    end
  endtask

  task automatic send_bit(input bit b);
    rst = 1'b1;
    sin = b;
    model_bit(b);
    @(negedge clk);
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 0; i < 10; i++) send_bit(w[i]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sin = 1'b0;
    #2;
    sb.delete();
    model_reset();
    @(negedge clk);
    check("rst_word", 32'(word), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    armed = 1'b1;
  endtask

  task automatic acquire(input logic [9:0] tok, input int max_words);
    for (int i = 0; i < max_words && locked !== 1'b1; i++) send_word(tok);
  endtask

  always @(posedge clk) bitno <= (rst === 1'b1) ? bitno + 1 : 0;

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (armed) begin
        if (word_valid === 1'b1) begin
          if (sb.size() == 0) check("strobe_unexpected", 32'(word_valid), 32'd0);
          else begin
            e = sb.pop_front();
            check("strobe_time", 32'(bitno), 32'(e.at));
            check("word", 32'(word), 32'(e.word));
            check("locked", 32'(locked), 32'(e.locked));
            check("phase", 32'(phase), 32'(e.phase));
          end
        end else if (word_valid !== 1'b0) begin
          check("word_valid_known", 32'(word_valid), 32'd0);
        end else if (sb.size() > 0 && bitno >= sb[0].at) begin
          check("strobe_missing", 32'(word_valid), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int drops;
    rst = 1'b0;
    sin = 1'b0;
    @(negedge clk);

    // Aligned start
    do_reset();
    for (int i = 0; i < 10; i++) send_word(TOK1);
    check("aligned_locked", 32'(locked), 32'd1);
    check("aligned_phase", 32'(phase), 32'd0);

    // Offset stream: three garbage bits ahead of the tokens
    do_reset();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    acquire(TOK0, 250);
    check("offset_locked", 32'(locked), 32'd1);
    check("offset_phase", 32'(phase), 32'd3);
    for (int i = 0; i < 3; i++) send_word(TOK0);

    // False start: verify aborted by one data word
    do_reset();
    for (int i = 0; i < 5; i++) send_word(TOK1);
    send_word(FALSE_DATA);
    send_word(TOK1);
    check("false_start_phase", 32'(phase), 32'd1);
    check("false_start_unlocked", 32'(locked), 32'd0);
    acquire(TOK1, 250);
    check("false_start_relock", 32'(locked), 32'd1);
    check("false_start_final_phase", 32'(phase), 32'd0);

    // Lock loss: one word short holds, full count drops
    for (int i = 0; i < LOSS_WORDS - 1; i++) send_word(rand_data());
    send_word(TOK1);
    check("loss_short_held", 32'(locked), 32'd1);
    for (int i = 0; i < LOSS_WORDS; i++) send_word(rand_data());
    send_word(rand_data());
    check("loss_dropped", 32'(locked), 32'd0);
    check("loss_phase", 32'(phase), 32'd1);

    // Mid-operation reset while locked
    acquire(TOK1, 250);
    check("reacquire_after_loss", 32'(locked), 32'd1);
    do_reset();
    acquire(TOK1, 20);
    check("reset_relock", 32'(locked), 32'd1);
    check("reset_relock_phase", 32'(phase), 32'd0);

    // Blanking/active mix
    drops = 0;
    for (int line = 0; line < 10; line++) begin
      for (int i = 0; i < 40; i++) begin
        case ($urandom_range(3))
          0: send_word(TOK0);
          1: send_word(TOK1);
          2: send_word(TOK2);
          default: send_word(TOK3);
        endcase
        if (locked !== 1'b1) drops++;
      end
      for (int i = 0; i < 160; i++) begin
        send_word(rand_data());
        if (locked !== 1'b1) drops++;
      end
    end
    check("mix_lock_drops", 32'(drops), 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
